// File: rtl/timer_cnt_core_if.sv
// ---------------------------------------------------------------------------
// timer_cnt_core_if
// Bundle between the timer register file and the counting core.
//   master : register-file side; drives tdr/load/updown/en/cks and
//            reads back tcnt plus the event pulses.
//   slave  : counting core side.
// Signals:
//   tdr       load value (TDR)
//   load      TCR[7], level load of tdr into TCNT
//   updown    TCR[5], 0 = up, 1 = down
//   en        TCR[4], count enable
//   cks       TCR[1:0], prescale select pclk/2,/4,/8,/16
//   tcnt      counter read-back
//   cnt_tick  one-cycle pulse per TCNT step
//   ovf_pulse one-cycle pulse on FF->00 while counting up
//   udf_pulse one-cycle pulse on 00->FF while counting down
// ---------------------------------------------------------------------------
interface timer_cnt_core_if #(
   parameter int CNT_W = 8
);
   logic [CNT_W-1:0] tdr;
   logic             load;
   logic             updown;
   logic             en;
   logic [1:0]       cks;
   logic [CNT_W-1:0] tcnt;
   logic             cnt_tick;
   logic             ovf_pulse;
   logic             udf_pulse;

   modport master (
      output tdr, load, updown, en, cks,
      input  tcnt, cnt_tick, ovf_pulse, udf_pulse
   );

   modport slave (
      input  tdr, load, updown, en, cks,
      output tcnt, cnt_tick, ovf_pulse, udf_pulse
   );
endinterface

// File: rtl/timer_cnt_core.sv
// ---------------------------------------------------------------------------
// timer_cnt_core
// Counting engine of the 8-bit timer: clock-select prescaler, up/down
// counter TCNT and registered overflow/underflow event pulses.
// Ports:
//   pclk     system clock
//   presetn  asynchronous active-low reset
//   bus      timer_cnt_core_if.slave (tdr, load, updown, en, cks in;
//            tcnt, cnt_tick, ovf_pulse, udf_pulse out)
// Optional feature: define TIMER_CNT_ONESHOT_EN for one-shot mode; the
// counter stops in DONE after the first wrap until en drops or load rises.
// ---------------------------------------------------------------------------
module timer_cnt_core #(
   parameter int CNT_W = 8,
   parameter int DIV_W = 4
) (
   input logic             pclk,
   input logic             presetn,
   timer_cnt_core_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d, mask;
   logic [CNT_W-1:0] tcnt_q, tcnt_d, cnt_nxt;
   logic             tick_q, ovf_q, udf_q;
   logic             run_c, tick_c, wrap_c, stop_c;

   // Prescale mask: cks = n selects the low n+1 div bits.
   always_comb begin
      mask = '0;
      for (int i = 0; i < DIV_W; i++)
         mask[i] = (i <= int'(bus.cks));
   end

   // State register
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.en && !bus.load) state_d = S_RUN;
         S_RUN: begin
            if (!bus.en || bus.load) state_d = S_IDLE;
`ifdef TIMER_CNT_ONESHOT_EN
            else if (tick_c && wrap_c) state_d = S_DONE;
`endif
         end
         S_DONE:  if (!bus.en || bus.load) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs. en/load are also qualified combinationally so a dropping
   // enable or a load on the tick cycle suppresses that tick outright.
   always_comb begin
      run_c   = (state_q == S_RUN) && bus.en && !bus.load;
      tick_c  = run_c && ((div_q & mask) == mask);
      cnt_nxt = bus.updown ? tcnt_q - CNT_W'(1) : tcnt_q + CNT_W'(1);
      // Wrap is judged against the direction sampled on this tick.
      wrap_c  = bus.updown ? (tcnt_q == '0) : (tcnt_q == '1);
`ifdef TIMER_CNT_ONESHOT_EN
      stop_c  = tick_c && wrap_c;
`else
      stop_c  = 1'b0;
`endif
   end

   // Datapath next state: load beats counting; div restarts whenever not running.
   always_comb begin
      div_d  = (run_c && !stop_c) ? div_q + DIV_W'(1) : '0;
      tcnt_d = tcnt_q;
      if (bus.load)    tcnt_d = bus.tdr;
      else if (tick_c) tcnt_d = cnt_nxt;
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         div_q  <= '0;
         tcnt_q <= '0;
         tick_q <= 1'b0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         div_q  <= div_d;
         tcnt_q <= tcnt_d;
         tick_q <= tick_c;
         ovf_q  <= tick_c && !bus.updown && wrap_c;
         udf_q  <= tick_c &&  bus.updown && wrap_c;
      end
   end

   assign bus.tcnt      = tcnt_q;
   assign bus.cnt_tick  = tick_q;
   assign bus.ovf_pulse = ovf_q;
   assign bus.udf_pulse = udf_q;

endmodule

// File: tb/tb_timer_cnt_core.sv
// ---------------------------------------------------------------------------
// tb_timer_cnt_core
// Scoreboard bench for timer_cnt_core. Each run segment computes from the
// prescale period which TCNT steps must appear and in which cycle, pushes
// them into a queue, and a negedge monitor pops one entry per observed
// event and compares cycle, value and pulses.
// ---------------------------------------------------------------------------
module tb_timer_cnt_core;

   logic pclk = 1'b0;
   logic presetn = 1'b0;
   always #5 pclk = ~pclk;

   timer_cnt_core_if #(.CNT_W(8)) bus ();

   timer_cnt_core #(.CNT_W(8), .DIV_W(4)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus.slave)
   );

`ifdef TIMER_CNT_ONESHOT_EN
   localparam bit ONESHOT = 1'b1;
`else
   localparam bit ONESHOT = 1'b0;
`endif

   typedef struct {
      int         cyc;
      logic [7:0] v;
      bit         ov;
      bit         ud;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] cur = 8'h00;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every event the DUT presents must match the next expected step.
   always @(negedge pclk) begin
      if (presetn && (bus.cnt_tick || bus.ovf_pulse || bus.udf_pulse)) begin
         n_chk++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: cyc=%0d tcnt=%02h tick=%b ovf=%b udf=%b, expected no event",
                     cyc, bus.tcnt, bus.cnt_tick, bus.ovf_pulse, bus.udf_pulse);
         end else begin
            mon_e = q.pop_front();
            if (cyc !== mon_e.cyc || bus.tcnt !== mon_e.v || bus.cnt_tick !== 1'b1 ||
                bus.ovf_pulse !== mon_e.ov || bus.udf_pulse !== mon_e.ud) begin
               n_fail++;
               $display("FAIL step: got cyc=%0d tcnt=%02h tick=%b ovf=%b udf=%b, expected cyc=%0d tcnt=%02h tick=1 ovf=%b udf=%b",
                        cyc, bus.tcnt, bus.cnt_tick, bus.ovf_pulse, bus.udf_pulse,
                        mon_e.cyc, mon_e.v, mon_e.ov, mon_e.ud);
            end
         end
      end
   end

   // Reference: with en raised before edge E0 and held for n edges, step k
   // (period p = 2^(cks+1)) lands at edge E(k*p) for every k*p <= n-1.
   task automatic run_seg(input bit do_load, input logic [7:0] v, input bit dn,
                          input logic [1:0] ck, input int n, input string nm);
      int   p, c0;
      logic ov, ud;
      if (do_load) begin
         @(negedge pclk);
         bus.tdr = v; bus.load = 1'b1; bus.en = 1'b0;
         @(negedge pclk);
         bus.load = 1'b0;
         cur = v;
         chk({nm, "_load"}, 64'(bus.tcnt), 64'(v));
      end
      @(negedge pclk);
      bus.updown = dn; bus.cks = ck; bus.en = 1'b1;
      c0 = cyc + 1;
      p  = 2 << ck;
      for (int k = 1; k * p <= n - 1; k++) begin
         cur = dn ? cur - 8'd1 : cur + 8'd1;
         ov  = !dn && (cur == 8'h00);
         ud  =  dn && (cur == 8'hFF);
         q.push_back('{c0 + k * p, cur, ov, ud});
         if (ONESHOT && (ov || ud)) break;
      end
      repeat (n) @(negedge pclk);
      bus.en = 1'b0;
      repeat (3) @(negedge pclk);
      chk({nm, "_tcnt"}, 64'(bus.tcnt), 64'(cur));
      chk({nm, "_drained"}, 64'(q.size()), 64'd0);
   endtask

   initial begin
      int c0, bad;
      bus.tdr = 8'h00; bus.load = 1'b0; bus.updown = 1'b0; bus.en = 1'b0; bus.cks = 2'b00;
      repeat (3) @(negedge pclk);
      chk("rst_tcnt", 64'(bus.tcnt), 64'd0);
      chk("rst_tick", 64'(bus.cnt_tick), 64'd0);
      chk("rst_ovf", 64'(bus.ovf_pulse), 64'd0);
      chk("rst_udf", 64'(bus.udf_pulse), 64'd0);
      presetn = 1'b1;
      repeat (4) @(negedge pclk);
      chk("idle_tcnt", 64'(bus.tcnt), 64'd0);

      run_seg(1'b1, 8'h00, 1'b0, 2'b00, 513, "ovf_div2");
      run_seg(1'b1, 8'hFC, 1'b0, 2'b01, 17, "ovf_div4");
      run_seg(1'b1, 8'h02, 1'b1, 2'b11, 49, "udf_div16");

      // Load asserted on the cycle of the FF->00 tick: no step, no ovf.
      @(negedge pclk);
      bus.tdr = 8'hFE; bus.load = 1'b1; bus.en = 1'b0;
      @(negedge pclk);
      bus.load = 1'b0; cur = 8'hFE;
      @(negedge pclk);
      bus.updown = 1'b0; bus.cks = 2'b00; bus.en = 1'b1;
      c0 = cyc + 1;
      q.push_back('{c0 + 2, 8'hFF, 1'b0, 1'b0});
      repeat (4) @(negedge pclk);
      bus.tdr = 8'h10; bus.load = 1'b1;
      @(negedge pclk);
      bus.load = 1'b0; bus.en = 1'b0; cur = 8'h10;
      chk("load_on_tick_tcnt", 64'(bus.tcnt), 64'h10);
      repeat (3) @(negedge pclk);
      chk("load_on_tick_drained", 64'(q.size()), 64'd0);

      run_seg(1'b0, 8'h00, 1'b0, 2'b00, 33, "resume_to_20");
      bad = 0;
      repeat (50) begin
         @(negedge pclk);
         if (bus.tcnt !== 8'h20) bad++;
      end
      chk("freeze_cycles_off", 64'(bad), 64'd0);

      // One-shot: a single wrap then hold (plain build keeps counting).
      run_seg(1'b1, 8'hFF, 1'b0, 2'b00, 201, "oneshot");
      run_seg(1'b0, 8'h00, 1'b0, 2'b00, 21, "reenable");

      for (int i = 0; i < 14; i++)
         run_seg(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), int'($urandom_range(2, 90)), "rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_cnt_core.md
Name: timer_cnt_core

Overview:
- Counting engine of the 8-bit timer IP: clock-select prescaler, 8-bit up/down counter TCNT, overflow/underflow event generation.
- Sits between the register file and the status register.
  - Upstream: register file supplies TDR and TCR fields.
  - Downstream: status register TSR consumes the one-cycle ovf/udf pulses to set its sticky flags.
- All timing is in pclk cycles.

Parameters:
- CNT_W, 8, counter/TDR width.
- DIV_W, 4, prescaler width; supports divide by 2/4/8/16.

Ports:
- pclk  in  1  system clock (APB clock).
- presetn  in  1  asynchronous active-low reset.
- tdr  in  CNT_W  load value (TDR).
- load  in  1  TCR[7]; level, TCNT <= tdr while high.
- updown  in  1  TCR[5]; 0 = count up, 1 = count down.
- en  in  1  TCR[4]; counting enable.
- cks  in  2  TCR[1:0]; 00 = pclk/2, 01 = pclk/4, 10 = pclk/8, 11 = pclk/16.
- tcnt  out  CNT_W  current counter value (read-back).
- cnt_tick  out  1  one-cycle pulse on each TCNT step.
- ovf_pulse  out  1  one-cycle pulse, up-count wrap FF->00.
- udf_pulse  out  1  one-cycle pulse, down-count wrap 00->FF.

Behaviour:
- Reset (presetn = 0, asynchronous):
  - tcnt = 0, div = 0, cnt_tick = 0, ovf_pulse = 0, udf_pulse = 0.
  - FSM = IDLE.
- FSM states:
  - IDLE: en = 0 or load = 1.
  - RUN: en = 1 and load = 0.
  - DONE: one-shot only; see Optional Feature.
- FSM transitions:
  - IDLE -> RUN when en = 1 and load = 0.
  - RUN -> IDLE when en = 0 or load = 1.
- Prescaler:
  - div increments every pclk in RUN; wraps at 2^DIV_W.
  - div is cleared to 0 in IDLE and on any load.
  - mask by cks: 00 -> 4'b0001, 01 -> 4'b0011, 10 -> 4'b0111, 11 -> 4'b1111.
  - tick_c = RUN and ((div & mask) == mask).
- Counter step: on tick_c, tcnt <= tcnt + 1 (updown = 0) or tcnt - 1 (updown = 1), modulo 2^CNT_W.
- First step timing: with cks = 00, first increment lands 2 pclk after the edge that sampled en = 1.
- Overflow timing: from tcnt = V counting up at pclk/2, overflow lands (256 - V)*2 pclk after enable.
- Event pulses:
  - ovf_pulse is registered and asserted for exactly one cycle, in the same cycle tcnt becomes 00 from FF (up-count).
  - udf_pulse likewise, in the same cycle tcnt becomes FF from 00 (down-count).
  - cnt_tick is registered and aligned with the tcnt update.
- Load:
  - load = 1 has priority over counting: tcnt <= tdr every cycle while high.
  - No tick and no flag while load = 1, including when load coincides with a tick.
  - Counting resumes with the next en cycle after load drops; div restarts at 0.
- Enable drop: en = 0 freezes tcnt at its current value and clears div. Re-enable restarts the full prescaler period.
- cks change mid-count: div is not cleared; the new mask applies from the next cycle. No glitch pulse is allowed.
- updown change mid-count: takes effect on the next tick. Wrap is detected against the direction sampled at that tick.
- tcnt is free-running (wraps); pulses never assert for two consecutive cycles.

Optional Feature:
- Macro: TIMER_CNT_ONESHOT_EN.
- Defined:
  - After an ovf/udf event the FSM goes RUN -> DONE.
  - In DONE: tcnt holds the wrapped value (00 or FF), div is held at 0, no further ticks.
  - DONE -> IDLE only when en = 0 or load = 1.
- Undefined: DONE state absent; counter keeps wrapping.

Test Plan:
- Reset, then check outputs with no enable -> tcnt = 00, all pulses 0.
- tdr = 8'h00, pulse load, then en = 1, cks = 00, up -> tcnt = 8'h01 after 2 pclk; ovf_pulse one cycle at 512 pclk, tcnt = 00.
- tdr = 8'hFC, load, en = 1, cks = 01, up -> tcnt steps every 4 pclk; ovf_pulse at 16 pclk, never earlier (sample TSR-side at 15 -> 0).
- tdr = 8'h02, load, en = 1, cks = 11, down -> udf_pulse at 48 pclk, tcnt = 8'hFF; no ovf_pulse.
- Counting up from 8'hFE, assert load with tdr = 8'h10 on the tick cycle -> tcnt = 8'h10, no ovf_pulse. Drop en at 8'h20 -> tcnt frozen for 50 cycles.
- With TIMER_CNT_ONESHOT_EN: count up from 8'hFF at cks = 00 -> single ovf_pulse, tcnt stays 00 for 100 pclk. en low then high -> counting resumes.
